// File: rtl/dff_chain_monitor.sv
// rtl/dff_chain_monitor.sv - locks to a DFF chain's latency and counts mismatches; DFF_MON_STICKY_EN adds sticky_err
module dff_chain_monitor #(
    parameter int MAX_DELAY   = 8,
    parameter int MATCH_LEN   = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           in,
    input  logic                           delayed,
    output logic                           locked,
    output logic [$clog2(MAX_DELAY+1)-1:0] delay_found,
    output logic                           err_pulse,
    output logic [ERR_W-1:0]               err_count
`ifdef DFF_MON_STICKY_EN
    ,
    output logic                           sticky_err
`endif
);

    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int RW = $clog2(MATCH_LEN + 1);
    localparam int CW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t state, state_next;

    logic [MAX_DELAY:1] hist;
    logic [DW-1:0]      cand;
    logic [DW-1:0]      fill_cnt;
    logic [RW-1:0]      run_cnt;
    logic [CW-1:0]      consec_err;

    logic tap_cand;
    logic tap_found;
    logic search_match;
    logic lock_match;
    logic fill_done;
    logic hit_lock;
    logic lose_lock;

    // Tap muxes written as loops so an out-of-range index simply reads 0.
    always_comb begin
        tap_cand  = 1'b0;
        tap_found = 1'b0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (cand == DW'(k)) begin
                tap_cand = hist[k];
            end
            if (delay_found == DW'(k)) begin
                tap_found = hist[k];
            end
        end
    end

    always_comb begin
        search_match = (delayed == tap_cand);
        lock_match   = (delayed == tap_found);
        fill_done    = (state == S_FILL) && (fill_cnt == DW'(MAX_DELAY - 1));
        hit_lock     = (state == S_SEARCH) && search_match
                       && (run_cnt == RW'(MATCH_LEN - 1));
        lose_lock    = (state == S_LOCKED) && !lock_match
                       && (consec_err == CW'(LOSS_THRESH - 1));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FILL:   if (fill_done) state_next = S_SEARCH;
            S_SEARCH: if (hit_lock)  state_next = S_LOCKED;
            S_LOCKED: if (lose_lock) state_next = S_SEARCH;
            default:  state_next = S_FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            hist <= '0;
        end else begin
            hist[1] <= in;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fill_cnt    <= '0;
            cand        <= DW'(1);
            run_cnt     <= '0;
            consec_err  <= '0;
            locked      <= 1'b0;
            delay_found <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            err_pulse <= 1'b0;
            locked    <= (state_next == S_LOCKED);
            unique case (state)
                S_FILL: begin
                    fill_cnt <= fill_cnt + DW'(1);
                end
                S_SEARCH: begin
                    if (search_match) begin
                        if (hit_lock) begin
                            delay_found <= cand;
                            run_cnt     <= '0;
                        end else begin
                            run_cnt <= run_cnt + RW'(1);
                        end
                    end else begin
                        run_cnt <= '0;
                        cand    <= (cand == DW'(MAX_DELAY)) ? DW'(1) : cand + DW'(1);
                    end
                end
                S_LOCKED: begin
                    if (!lock_match) begin
                        err_pulse <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        // The mismatch that drops lock is still counted above.
                        if (lose_lock) begin
                            cand       <= DW'(1);
                            run_cnt    <= '0;
                            consec_err <= '0;
                        end else begin
                            consec_err <= consec_err + CW'(1);
                        end
                    end else begin
                        consec_err <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DFF_MON_STICKY_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sticky_err <= 1'b0;
        end else if (state == S_LOCKED && !lock_match) begin
            sticky_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dff_chain_monitor.sv
// tb/tb_dff_chain_monitor.sv - randomized bench for dff_chain_monitor against a queue-based reference model
module tb_dff_chain_monitor;

    localparam int MAXD = 8;
    localparam int ML   = 16;
    localparam int LT   = 4;
    localparam int EW   = 4;
    localparam int DW   = $clog2(MAXD + 1);

    localparam int M_FILL   = 0;
    localparam int M_SEARCH = 1;
    localparam int M_LOCKED = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          in = 1'b0;
    logic          delayed = 1'b0;
    logic          locked;
    logic [DW-1:0] delay_found;
    logic          err_pulse;
    logic [EW-1:0] err_count;
`ifdef DFF_MON_STICKY_EN
    logic          sticky_err;
`endif

    dff_chain_monitor #(
        .MAX_DELAY  (MAXD),
        .MATCH_LEN  (ML),
        .LOSS_THRESH(LT),
        .ERR_W      (EW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in         (in),
        .delayed    (delayed),
        .locked     (locked),
        .delay_found(delay_found),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
`ifdef DFF_MON_STICKY_EN
        ,
        .sticky_err (sticky_err)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: past[k-1] holds the in value sampled k edges ago.
    bit past[$];
    int m_mode = M_FILL;
    int m_fill = 0, m_cand = 1, m_run = 0, m_consec = 0, m_found = 0, m_cnt = 0;
    bit m_pulse = 0, m_sticky = 0;

    function automatic void model_edge(input bit r, input bit i, input bit d);
        if (!r) begin
            past.delete();
            for (int k = 0; k < MAXD; k++) past.push_back(1'b0);
            m_mode = M_FILL; m_fill = 0; m_cand = 1; m_run = 0; m_consec = 0;
            m_found = 0; m_cnt = 0; m_pulse = 0; m_sticky = 0;
            return;
        end
        m_pulse = 0;
        if (m_mode == M_FILL) begin
            if (m_fill == MAXD - 1) m_mode = M_SEARCH;
            m_fill++;
        end else if (m_mode == M_SEARCH) begin
            if (d == past[m_cand-1]) begin
                m_run++;
                if (m_run == ML) begin
                    m_mode = M_LOCKED; m_found = m_cand; m_run = 0;
                end
            end else begin
                m_run = 0;
                m_cand = m_cand % MAXD + 1;
            end
        end else begin
            if (d != past[m_found-1]) begin
                m_pulse = 1; m_sticky = 1;
                if (m_cnt < (1 << EW) - 1) m_cnt++;
                m_consec++;
                if (m_consec == LT) begin
                    m_mode = M_SEARCH; m_cand = 1; m_run = 0; m_consec = 0;
                end
            end else begin
                m_consec = 0;
            end
        end
        past.push_front(i);
        void'(past.pop_back());
    endfunction

    // Simulated chain: drv[k-1] is the in value driven k cycles ago.
    bit drv[$];
    int n_chain = 3;

    task automatic step(input bit rst_v, input bit invert);
        bit ni;
        ni = 1'($urandom);
        RST = rst_v;
        in = ni;
        delayed = drv[n_chain-1] ^ invert;
        drv.push_front(ni);
        void'(drv.pop_back());
        @(posedge CLK);
        model_edge(rst_v, ni, delayed);
        #1;
        check_val("locked", locked, (m_mode == M_LOCKED));
        check_val("delay_found", delay_found, m_found);
        check_val("err_pulse", err_pulse, m_pulse);
        check_val("err_count", err_count, m_cnt);
`ifdef DFF_MON_STICKY_EN
        check_val("sticky_err", sticky_err, m_sticky);
`endif
    endtask

    task automatic wait_lock(input int budget);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step(1'b1, 1'b0);
            n++;
        end
        check_val("lock_within_budget", locked, 1);
    endtask

    int seen_lock;

    initial begin
        for (int k = 0; k < 16; k++) drv.push_back(1'b0);
        for (int k = 0; k < MAXD; k++) past.push_back(1'b0);

        n_chain = 3;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("rst_locked", locked, 0);
        check_val("rst_err_count", err_count, 0);
        check_val("rst_delay_found", delay_found, 0);

        wait_lock(200);
        check_val("lock3_found", delay_found, 3);
        check_val("lock3_errs", err_count, 0);

        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_val("single_pulse", err_pulse, 1);
        check_val("single_count", err_count, 1);
        check_val("single_locked", locked, 1);
        step(1'b1, 1'b0);
        check_val("pulse_width", err_pulse, 0);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        for (int k = 0; k < LT; k++) step(1'b1, 1'b1);
        check_val("loss_count", err_count, 5);
        check_val("loss_unlocked", locked, 0);
        check_val("loss_keep_found", delay_found, 3);
        wait_lock(200);
        check_val("relock_found", delay_found, 3);

        step(1'b0, 1'b0);
        n_chain = MAXD;
        wait_lock(200);
        check_val("lock_max_found", delay_found, MAXD);

        step(1'b0, 1'b0);
        n_chain = MAXD + 1;
        seen_lock = 0;
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b0);
            if (locked === 1'b1) seen_lock++;
        end
        check_val("chain9_never_locked", seen_lock, 0);

        step(1'b0, 1'b0);
        n_chain = 3;
        wait_lock(200);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1);
            for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
        end
        check_val("err_saturated", err_count, (1 << EW) - 1);
        check_val("sat_still_locked", locked, 1);
        step(1'b0, 1'b0);
        check_val("sat_rst_count", err_count, 0);
        check_val("sat_rst_locked", locked, 0);

`ifdef DFF_MON_STICKY_EN
        wait_lock(200);
        step(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        check_val("sticky_held", sticky_err, 1);
        step(1'b0, 1'b0);
        check_val("sticky_rst", sticky_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
